// File: rtl/car_voltage_monitor.sv
// Multi-channel voltage monitor: per-channel LAST/AVG/MIN/MAX statistics, an undervoltage
// threshold with sticky status and masked interrupt, all behind an Avalon-MM slave.

module car_voltage_monitor_ch #(
  parameter int DATA_W   = 12,
  parameter int AVG_LOG2 = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic              clr,
  input  logic [DATA_W-1:0] sample,
  output logic [DATA_W-1:0] last,
  output logic [DATA_W-1:0] avg,
  output logic [DATA_W-1:0] min_v,
  output logic [DATA_W-1:0] max_v
);
  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int LEN   = 1 << AVG_LOG2;

  logic [DATA_W-1:0] last_q, last_d, avg_q, avg_d, min_q, min_d, max_q, max_d;
  logic [ACC_W-1:0]  acc_q, acc_d, sum;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign sum = acc_q + ACC_W'(sample);

  always_comb begin
    last_d = last_q;
    avg_d  = avg_q;
    min_d  = min_q;
    max_d  = max_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    if (valid) last_d = sample;
    // A stats clear wins over a coincident sample; LAST still takes it.
    if (clr) begin
      min_d = '1;
      max_d = '0;
      acc_d = '0;
      cnt_d = '0;
    end else if (valid) begin
      if (sample < min_q) min_d = sample;
      if (sample > max_q) max_d = sample;
      if (cnt_q == CNT_W'(LEN - 1)) begin
        avg_d = DATA_W'(sum >> AVG_LOG2);
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= '0;
      avg_q  <= '0;
      min_q  <= '1;
      max_q  <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
    end else begin
      last_q <= last_d;
      avg_q  <= avg_d;
      min_q  <= min_d;
      max_q  <= max_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
    end
  end

  // Single-sample "blocks" make the average identical to the last sample.
  assign avg   = (AVG_LOG2 == 0) ? last_q : avg_q;
  assign last  = last_q;
  assign min_v = min_q;
  assign max_v = max_q;
endmodule

module car_voltage_monitor #(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 12,
  parameter int AVG_LOG2 = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [5:0]               address,
  input  logic                     chipselect,
  input  logic                     write_n,
  input  logic [31:0]              writedata,
  output logic [31:0]              readdata,
  input  logic [NUM_CH*DATA_W-1:0] in_port,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic                     irq
);
  logic [NUM_CH-1:0][DATA_W-1:0] smp, last, avg, min_v, max_v;
  logic [DATA_W-1:0] thresh_q, thresh_d;
  logic [NUM_CH-1:0] mask_q, mask_d, status_q, status_d, set_v, w1c;
  logic [31:0]       readdata_q, readdata_d;
  logic              irq_q, irq_d, wr_en, clr_stats, unused_wd;

  assign smp       = in_port;
  assign wr_en     = chipselect & ~write_n;
  assign clr_stats = wr_en && (address == 6'h23) && writedata[0];
  assign unused_wd = ^writedata;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    car_voltage_monitor_ch #(.DATA_W(DATA_W), .AVG_LOG2(AVG_LOG2)) u_ch (
      .clk(clk), .reset(reset), .valid(in_valid[c]), .clr(clr_stats), .sample(smp[c]),
      .last(last[c]), .avg(avg[c]), .min_v(min_v[c]), .max_v(max_v[c])
    );
  end

  always_comb begin
    set_v = '0;
    for (int c = 0; c < NUM_CH; c++) set_v[c] = in_valid[c] && (smp[c] < thresh_q);
    w1c      = (wr_en && address == 6'h22) ? writedata[NUM_CH-1:0] : '0;
    // Set is OR-ed after the clear so a coincident set survives.
    status_d = (status_q & ~w1c) | set_v;
    thresh_d = (wr_en && address == 6'h20) ? writedata[DATA_W-1:0] : thresh_q;
    mask_d   = (wr_en && address == 6'h21) ? writedata[NUM_CH-1:0] : mask_q;
    irq_d    = |(status_q & mask_q);
  end

  always_comb begin
    readdata_d = '0;
    if (!address[5]) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (address[4:2] == 3'(c)) begin
          case (address[1:0])
            2'd0:    readdata_d = 32'(last[c]);
            2'd1:    readdata_d = 32'(avg[c]);
            2'd2:    readdata_d = 32'(min_v[c]);
            default: readdata_d = 32'(max_v[c]);
          endcase
        end
      end
    end else begin
      case (address[4:0])
        5'h00:   readdata_d = 32'(thresh_q);
        5'h01:   readdata_d = 32'(mask_q);
        5'h02:   readdata_d = 32'(status_q);
        default: readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      thresh_q   <= '0;
      mask_q     <= '0;
      status_q   <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      thresh_q   <= thresh_d;
      mask_q     <= mask_d;
      status_q   <= status_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;
endmodule

// File: tb/tb_car_voltage_monitor.sv
// Bench for car_voltage_monitor: directed scenarios plus randomized traffic against a
// queue-based model of the statistics, threshold status and register map.
module tb_car_voltage_monitor;
  localparam int NC = 4, DW = 12, AL = 3, N = 1 << AL, ALL1 = (1 << DW) - 1;

  logic              clk = 1'b0, reset = 1'b0;
  logic [5:0]        address = '0;
  logic              chipselect = 1'b0, write_n = 1'b1;
  logic [31:0]       writedata = '0, readdata;
  logic [NC*DW-1:0]  in_port = '0;
  logic [NC-1:0]     in_valid = '0;
  logic              irq;

  always #5 clk = ~clk;

  car_voltage_monitor #(.NUM_CH(NC), .DATA_W(DW), .AVG_LOG2(AL)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata), .in_port(in_port), .in_valid(in_valid), .irq(irq)
  );

  int checks = 0, failures = 0;
  int m_last[NC], m_avg[NC], m_min[NC], m_max[NC];
  int hist[NC][$];
  int m_thresh, m_mask, m_status;
  logic [31:0] exp_rd;
  logic        exp_irq;

  function automatic int sample_of(int c);
    return int'(in_port[c*DW +: DW]);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_last[c] = 0; m_avg[c] = 0; m_max[c] = 0; m_min[c] = ALL1;
      hist[c].delete();
    end
    m_thresh = 0; m_mask = 0; m_status = 0;
  endtask

  function automatic logic [31:0] model_read(logic [5:0] a);
    int c = int'(a[4:2]);
    if (!a[5]) begin
      if (c >= NC) return 32'd0;
      case (a[1:0])
        2'd0:    return m_last[c];
        2'd1:    return m_avg[c];
        2'd2:    return m_min[c];
        default: return m_max[c];
      endcase
    end
    case (a[4:0])
      5'h00:   return m_thresh;
      5'h01:   return m_mask;
      5'h02:   return m_status;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_update();
    bit wr  = chipselect && !write_n;
    bit clr = wr && address == 6'h23 && writedata[0];
    int setb = 0, w1c = 0;
    for (int c = 0; c < NC; c++) begin
      if (in_valid[c]) begin
        int s = sample_of(c);
        if (s < m_thresh) setb |= (1 << c);
        m_last[c] = s;
        if (!clr) begin
          if (s < m_min[c]) m_min[c] = s;
          if (s > m_max[c]) m_max[c] = s;
          hist[c].push_back(s);
          if (hist[c].size() == N) begin
            int sum = 0;
            for (int i = 0; i < hist[c].size(); i++) sum += hist[c][i];
            m_avg[c] = sum / N;
            hist[c].delete();
          end
        end
      end
    end
    if (clr) for (int c = 0; c < NC; c++) begin
      m_min[c] = ALL1; m_max[c] = 0; hist[c].delete();
    end
    if (wr && address == 6'h22) w1c = int'(writedata[NC-1:0]);
    m_status = (m_status & ~w1c) | setb;
    if (wr && address == 6'h20) m_thresh = int'(writedata[DW-1:0]);
    if (wr && address == 6'h21) m_mask = int'(writedata[NC-1:0]);
  endtask

  // Advance one clock with the currently driven inputs; inputs change on negedges only.
  task automatic tick();
    exp_rd  = model_read(address);
    exp_irq = (m_status & m_mask) != 0;
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = '0; chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic set_sample(int c, int v);
    in_port[c*DW +: DW] = DW'(v);
  endtask

  task automatic wr(logic [5:0] a, logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    idle();
  endtask

  task automatic rd(logic [5:0] a);
    address = a;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (readdata !== 32'd0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs readdata=%0h irq=%0b expected 0/0", readdata, irq);
    end
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int a = 0; a < 64; a++) begin
      rd(6'(a));
      checks++;
      if (readdata !== exp_rd) begin
        failures++;
        $display("FAIL reset_reg addr=%0h got=%0h expected=%0h", a, readdata, exp_rd);
      end
    end
    rd(6'h02);
    checks++;
    if (readdata !== 32'hFFF) begin
      failures++;
      $display("FAIL reset_min0 got=%0h expected=fff", readdata);
    end
  endtask

  task automatic test_avg();
    for (int i = 1; i <= 8; i++) begin
      in_valid = 4'b0010; set_sample(1, i * 100);
      tick();
    end
    idle();
    rd(6'h05);
    checks++;
    if (readdata !== 32'd450) begin
      failures++; $display("FAIL avg_ch1 got=%0d expected=450", readdata);
    end
    rd(6'h06);
    checks++;
    if (readdata !== 32'd100) begin
      failures++; $display("FAIL min_ch1 got=%0d expected=100", readdata);
    end
    rd(6'h07);
    checks++;
    if (readdata !== 32'd800) begin
      failures++; $display("FAIL max_ch1 got=%0d expected=800", readdata);
    end
    rd(6'h04);
    checks++;
    if (readdata !== 32'd800) begin
      failures++; $display("FAIL last_ch1 got=%0d expected=800", readdata);
    end
  endtask

  task automatic test_irq();
    wr(6'h20, 32'hFFFF_F500);
    wr(6'h21, 32'h0000_00F4);
    in_valid = 4'b0100; set_sample(2, 'h4FF);
    tick();
    idle();
    rd(6'h22);
    checks++;
    if (readdata !== 32'h4 || irq !== 1'b1) begin
      failures++; $display("FAIL irq_set status=%0h irq=%0b expected 4/1", readdata, irq);
    end
    in_valid = 4'b1000; set_sample(3, 'h500);
    tick();
    idle();
    tick();
    checks++;
    if (readdata !== 32'h4) begin
      failures++; $display("FAIL irq_equal_thresh status=%0h expected=4", readdata);
    end
    wr(6'h22, 32'h4);
    checks++;
    if (irq !== 1'b1) begin
      failures++; $display("FAIL irq_before_clear irq=%0b expected=1", irq);
    end
    rd(6'h22);
    checks++;
    if (irq !== 1'b0 || readdata !== 32'h0) begin
      failures++; $display("FAIL irq_cleared irq=%0b status=%0h expected 0/0", irq, readdata);
    end
  endtask

  task automatic test_w1c_collision();
    chipselect = 1'b1; write_n = 1'b0; address = 6'h22; writedata = 32'h4;
    in_valid = 4'b0100; set_sample(2, 'h010);
    tick();
    idle();
    rd(6'h22);
    checks++;
    if (readdata !== 32'h4) begin
      failures++; $display("FAIL w1c_collision status=%0h expected=4", readdata);
    end
    wr(6'h22, 32'hF);
  endtask

  task automatic test_clear();
    chipselect = 1'b1; write_n = 1'b0; address = 6'h23; writedata = 32'h1;
    in_valid = 4'b0001; set_sample(0, 'h123);
    tick();
    idle();
    rd(6'h00);
    checks++;
    if (readdata !== 32'h123) begin
      failures++; $display("FAIL clear_last0 got=%0h expected=123", readdata);
    end
    rd(6'h02);
    checks++;
    if (readdata !== 32'hFFF) begin
      failures++; $display("FAIL clear_min0 got=%0h expected=fff", readdata);
    end
    rd(6'h03);
    checks++;
    if (readdata !== 32'h0) begin
      failures++; $display("FAIL clear_max0 got=%0h expected=0", readdata);
    end
    rd(6'h05);
    checks++;
    if (readdata !== 32'd450) begin
      failures++; $display("FAIL clear_keeps_avg1 got=%0d expected=450", readdata);
    end
    rd(6'h22);
    checks++;
    if (readdata !== 32'h1) begin
      failures++; $display("FAIL clear_status got=%0h expected=1", readdata);
    end
  endtask

  task automatic test_reset_mid_avg();
    int sum = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 4'b0001; set_sample(0, 4000);
      tick();
    end
    idle();
    do_reset();
    for (int a = 0; a < 64; a++) begin
      rd(6'(a));
      checks++;
      if (readdata !== exp_rd) begin
        failures++;
        $display("FAIL midavg_reset_reg addr=%0h got=%0h expected=%0h", a, readdata, exp_rd);
      end
    end
    for (int i = 0; i < 8; i++) begin
      int v = int'($urandom_range(0, ALL1));
      sum += v;
      in_valid = 4'b0001; set_sample(0, v);
      tick();
    end
    idle();
    rd(6'h01);
    checks++;
    if (readdata !== 32'(sum / 8)) begin
      failures++; $display("FAIL midavg_fresh_avg got=%0d expected=%0d", readdata, sum / 8);
    end
  endtask

  task automatic test_unmapped();
    logic [5:0] addrs [5] = '{6'h1C, 6'h1F, 6'h23, 6'h24, 6'h3F};
    wr(6'h23, 32'hFFFF_FFFE);
    for (int i = 0; i < 5; i++) begin
      rd(addrs[i]);
      checks++;
      if (readdata !== 32'd0) begin
        failures++; $display("FAIL unmapped addr=%0h got=%0h expected=0", addrs[i], readdata);
      end
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int n = 0; n < 2000; n++) begin
      in_valid = NC'($urandom);
      for (int c = 0; c < NC; c++) set_sample(c, int'($urandom_range(0, ALL1)));
      chipselect = $urandom_range(0, 1) == 1;
      write_n    = $urandom_range(0, 3) != 0;
      writedata  = $urandom;
      address    = 6'($urandom);
      if (!write_n && $urandom_range(0, 1) == 1)
        address = 6'h20 + 6'($urandom_range(0, 2));
      else if (address == 6'h23 && $urandom_range(0, 7) != 0)
        address = 6'h22;
      tick();
      checks++;
      if (readdata !== exp_rd || irq !== exp_irq) begin
        failures++;
        if (bad++ < 10)
          $display("FAIL random cyc=%0d readdata=%0h irq=%0b expected %0h/%0b",
                   n, readdata, irq, exp_rd, exp_irq);
      end
    end
    idle();
  endtask

  initial begin
    reset = 1'b1;
    model_reset();
    test_reset();
    test_avg();
    test_irq();
    test_w1c_collision();
    test_clear();
    test_reset_mid_avg();
    test_unmapped();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/car_voltage_monitor.md
CAR_VOLTAGE_MONITOR -- requirements
Module: car_voltage_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of sampled channels (1..8).
REQ-002 SHALL have parameter DATA_W, default 12, sample width in bits (1..16).
REQ-003 SHALL have parameter AVG_LOG2, default 3, where each block average covers 2^AVG_LOG2 samples (0..8).
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic rising-edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port address, input, 6 bits: Avalon-MM word address.
REQ-007 SHALL have port chipselect, input, 1 bit: slave select.
REQ-008 SHALL have port write_n, input, 1 bit: active-low write strobe, qualified by chipselect.
REQ-009 SHALL have port writedata, input, 32 bits: write data.
REQ-010 SHALL have port readdata, output, 32 bits: registered read data.
REQ-011 SHALL have port in_port, input, NUM_CH*DATA_W bits: channel ch occupies bits [ch*DATA_W +: DATA_W].
REQ-012 SHALL have port in_valid, input, NUM_CH bits: per-channel one-cycle sample strobe.
REQ-013 SHALL have port irq, output, 1 bit: registered, level-sensitive interrupt.

Function
REQ-014 SHALL map addresses with address[5]=0 to per-channel registers: ch=address[4:2], sel=address[1:0] (0 LAST, 1 AVG, 2 MIN, 3 MAX), all read-only and zero-extended.
REQ-015 SHALL map global registers 0x20 THRESH (RW, DATA_W bits), 0x21 IRQ_MASK (RW, NUM_CH bits), 0x22 IRQ_STATUS (read, write-1-to-clear), and 0x23 CTRL (write-only, bit0 = stats clear, self-clearing, reads 0).
REQ-016 SHALL update readdata every cycle from address with 1-cycle latency, independent of chipselect; reads of unmapped addresses or ch>=NUM_CH SHALL return 0.
REQ-017 SHALL ignore writes to read-only or unmapped addresses; write bits above the register width SHALL be ignored.
REQ-018 SHALL load LAST[ch] with the channel's in_port slice in the cycle after in_valid[ch]=1.
REQ-019 SHALL update MIN[ch]=min(MIN,sample) and MAX[ch]=max(MAX,sample) on each valid sample, using unsigned comparison.
REQ-020 SHALL keep per channel a DATA_W+AVG_LOG2-bit accumulator and an AVG_LOG2-bit sample counter; on the 2^AVG_LOG2-th sample, AVG[ch] SHALL load (acc+sample)>>AVG_LOG2 (truncated) and acc/counter SHALL return to 0 in the same cycle; accumulator overflow SHALL be impossible by width.
REQ-021 SHALL, when AVG_LOG2=0, make AVG[ch] equal LAST[ch].
REQ-022 SHALL set IRQ_STATUS[ch] on any valid sample strictly less than THRESH; a sample equal to THRESH SHALL NOT set it; status is sticky.
REQ-023 SHALL give priority to set when a W1C clear and a set hit the same bit in the same cycle.
REQ-024 SHALL drive irq = OR(IRQ_STATUS & IRQ_MASK), registered, so irq asserts 1 cycle after the status or mask change.
REQ-025 SHALL, on a CTRL bit0 write, set MIN to all-ones and MAX, acc and counter to 0 for all channels; AVG and LAST SHALL be kept; a sample arriving in the same cycle SHALL update LAST and status but SHALL NOT enter the stats (clear wins).
REQ-026 SHALL process simultaneous in_valid on multiple channels independently in the same cycle.

Reset
REQ-027 SHALL, while reset=1, force readdata, irq, LAST, AVG, MAX, acc, counter, THRESH, IRQ_MASK and IRQ_STATUS to 0, and MIN to all-ones; reset SHALL abort any partial average, with no resumption after release.

Verification
REQ-028 SHALL cover: ch1 samples 100,200,300,400,500,600,700,800 -> AVG[1]=450, MIN=100, MAX=800, read at 0x05 returns 450 one cycle after address.
REQ-029 SHALL cover: THRESH=0x500, IRQ_MASK=0x4, ch2 sample 0x4FF -> IRQ_STATUS=0x4, irq=1; sample 0x500 on ch3 -> status unchanged; write 0x4 to 0x22 -> irq falls.
REQ-030 SHALL cover: W1C of bit2 coincident with ch2 sample 0x010 below threshold -> bit2 stays 1.
REQ-031 SHALL cover: CTRL=1 write in the same cycle as ch0 sample 0x123 -> LAST[0]=0x123, MIN[0]=0xFFF, MAX[0]=0.
REQ-032 SHALL cover: reset asserted after 5 of 8 samples -> all registers at reset values; the next 8 samples yield a correct average.
REQ-033 SHALL cover: read of 0x1C with NUM_CH=4, and read of 0x23 -> 0.
